// File: rtl/tmds_rx_pkg.sv
// ---------------------------------------------------------------------------
// tmds_rx_pkg : shared constants, FSM state type and token test for the aligner
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tmds_rx_pkg;

  localparam int OFFSET_W = 4;

  localparam logic [9:0] CTRL_TOK0 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK1 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK2 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK3 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == CTRL_TOK0) || (word == CTRL_TOK1) ||
           (word == CTRL_TOK2) || (word == CTRL_TOK3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_gearbox_5to10.sv
// ---------------------------------------------------------------------------
// tmds_gearbox_5to10 : 5-bit chunk history and bit-offset window select
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmds_gearbox_5to10
  import tmds_rx_pkg::*;
(
  input  logic                clk_2x,
  input  logic                reset,
  input  logic [4:0]          in_data,
  input  logic                in_valid,
  input  logic [OFFSET_W-1:0] offset,
  output logic [9:0]          cand_word,
  output logic                cand_valid
);

  logic [19:0] hist;
  logic [19:0] hist_shift;
  logic        phase;
  logic [9:0]  win [10];

  // Newest chunk enters at the top so bit 0 stays the earliest wire bit.
  assign hist_shift = {in_data, hist[19:5]};

  always_ff @(posedge clk_2x) begin
    if (reset) begin
      hist  <= '0;
      phase <= 1'b0;
    end else if (in_valid) begin
      hist  <= hist_shift;
      phase <= ~phase;
    end
  end

  for (genvar i = 0; i < 10; i++) begin : g_win
    assign win[i] = hist_shift[i+9:i];
  end

  always_comb begin
    cand_word = win[0];
    for (int k = 1; k < 10; k++) begin
      if (offset == OFFSET_W'(k)) cand_word = win[k];
    end
  end

  assign cand_valid = in_valid & phase;

endmodule

`default_nettype wire

// File: rtl/tmds_rx_word_aligner.sv
// ---------------------------------------------------------------------------
// tmds_rx_word_aligner : control-token driven TMDS word alignment with lock FSM
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmds_rx_word_aligner
  import tmds_rx_pkg::*;
#(
  parameter int LOCK_TOKENS   = 16,
  parameter int TIMEOUT_WORDS = 2048
) (
  input  logic                clk_2x,
  input  logic                reset,
  input  logic [4:0]          in_data,
  input  logic                in_valid,
  output logic [9:0]          out_word,
  output logic                out_valid,
  output logic                out_token,
  output logic                locked,
  output logic [OFFSET_W-1:0] offset
);

  localparam int TOK_W = $clog2(LOCK_TOKENS) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_WORDS) + 1;
  localparam logic [TOK_W-1:0] LOCK_MAX = TOK_W'(LOCK_TOKENS);
  localparam logic [TMR_W-1:0] TMO_MAX  = TMR_W'(TIMEOUT_WORDS);

  logic [9:0]          cand_word;
  logic                cand_valid;
  logic                cand_tok;
  state_t              state, state_next;
  logic [TOK_W-1:0]    tok_cnt, tok_next, tok_inc;
  logic [TMR_W-1:0]    timer, timer_next, timer_inc;
  logic [OFFSET_W-1:0] offset_next;

  tmds_gearbox_5to10 u_gearbox (
    .clk_2x     (clk_2x),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .offset     (offset),
    .cand_word  (cand_word),
    .cand_valid (cand_valid)
  );

  assign cand_tok  = is_ctrl_token(cand_word);
  assign tok_inc   = (tok_cnt == '1) ? tok_cnt : tok_cnt + 1'b1;
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clk_2x) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  // Decisions are made on the candidate word so locked lines up with out_word.
  always_comb begin
    state_next  = state;
    tok_next    = tok_cnt;
    timer_next  = timer;
    offset_next = offset;
    if (cand_valid) begin
      case (state)
        SEARCH: begin
          tok_next   = cand_tok ? tok_inc : '0;
          timer_next = timer_inc;
          if (cand_tok && (tok_inc >= LOCK_MAX)) begin
            state_next = LOCKED;
            tok_next   = '0;
            timer_next = '0;
          end else if (timer_inc >= TMO_MAX) begin
            offset_next = (offset == OFFSET_W'(9)) ? '0 : offset + 1'b1;
            timer_next  = '0;
            tok_next    = '0;
          end
        end
        LOCKED: begin
          timer_next = cand_tok ? '0 : timer_inc;
          if (!cand_tok && (timer_inc >= TMO_MAX)) begin
            state_next = SEARCH;
            timer_next = '0;
            tok_next   = '0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk_2x) begin
    if (reset) begin
      tok_cnt   <= '0;
      timer     <= '0;
      offset    <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_token <= 1'b0;
    end else begin
      tok_cnt   <= tok_next;
      timer     <= timer_next;
      offset    <= offset_next;
      out_valid <= cand_valid;
      if (cand_valid) begin
        out_word  <= cand_word;
        out_token <= cand_tok;
      end
    end
  end

endmodule

`default_nettype wire
